ahb_ext_bridge: RTL and testbench
=================================

# ahb_ext_bridge

AHB-Lite subordinate that terminates the SoC's external-memory port (the HSELEXT region) and converts each AHB transfer into a single request/response transaction on a simple memory-side interface, for an off-chip DRAM/flash controller. It sits directly downstream of the SoC top and drives HRDATAEXT/HREADYEXT/HRESPEXT back into it. One transfer is outstanding at a time. Wait states are inserted until the memory completes. Illegal or timed-out transfers get the two-cycle AHB ERROR response.

## Interface

Parameters:
- AHBW, 64, AHB data width in bits (32 or 64).
- PA_BITS, 34, physical address width.
- TIMEOUT_CYCLES, 1023, wait-state limit before ERROR; only used with the timeout feature.

Ports:
- clk  in  1  system clock; all AHB and memory-side signals are synchronous to it.
- reset  in  1  synchronous, active-high reset.
- HSELEXT  in  1  region select from the uncore decoder.
- HADDR  in  PA_BITS  address-phase address.
- HTRANS  in  2  transfer type.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  transfer size (log2 bytes).
- HWDATA  in  AHBW  write data, valid in the data phase.
- HWSTRB  in  AHBW/8  write byte strobes, valid in the data phase.
- HREADY  in  1  global bus HREADY; an address phase is accepted only when it is high.
- HRDATAEXT  out  AHBW  read data.
- HREADYEXT  out  1  subordinate ready.
- HRESPEXT  out  1  1 = ERROR.
- MemReq  out  1  memory request valid; held until MemGnt.
- MemWrite  out  1  request is a write.
- MemAdr  out  PA_BITS  request address, aligned to AHBW/8 bytes.
- MemWData  out  AHBW  write data.
- MemByteEn  out  AHBW/8  byte enables; all ones for reads.
- MemGnt  in  1  memory accepted the request this cycle.
- MemDone  in  1  memory completed the accepted request; never asserted in the same cycle as MemGnt.
- MemRData  in  AHBW  read data, valid with MemDone.
- MemErr  in  1  completion error, valid with MemDone.

## Operation

- Accept: an address phase is accepted when HSELEXT & HTRANS[1] & HREADY are all high. On acceptance the bridge captures HADDR, HWRITE and HSIZE.
- Illegal accepted transfer (HSIZE > log2(AHBW/8), or HADDR not aligned to HSIZE): go to ERR1.
- IDLE/BUSY transfers (HTRANS[1]=0) get a zero-wait OKAY response.
- FSM states: IDLE, REQ, WAIT, DONE, ERR1, ERR2.
- IDLE: HREADYEXT=1, HRESPEXT=0. A legal accept goes to REQ.
- REQ: MemReq=1 with the captured address.
  - For writes, MemWData=HWDATA and MemByteEn=HWSTRB, registered on REQ entry and held.
  - HREADYEXT=0.
  - MemGnt goes to WAIT.
- WAIT: HREADYEXT=0.
  - MemDone & ~MemErr goes to DONE; for reads, MemRData is registered into HRDATAEXT.
  - MemDone & MemErr goes to ERR1.
- DONE: HREADYEXT=1, HRESPEXT=0. HRDATAEXT stays valid this cycle only. A new legal accept in the same cycle goes to REQ (back-to-back); otherwise go to IDLE.
- ERR1: HRESPEXT=1, HREADYEXT=0. Always goes to ERR2.
- ERR2: HRESPEXT=1, HREADYEXT=1. Accepts a new address phase exactly like DONE does.
- HRDATAEXT holds its last value outside DONE. Write completions leave it unchanged.

## Timing

- Reset values: HREADYEXT=1, HRESPEXT=0, HRDATAEXT=0, MemReq=0, MemWrite=0, MemAdr=0, MemWData=0, MemByteEn=0; state IDLE.
- Minimum latency: accept at cycle 0, REQ with MemGnt at cycle 1, MemDone at cycle 2, HREADYEXT=1 at cycle 3. This is two wait states.
- MemReq, MemAdr, MemWrite, MemWData and MemByteEn are stable from REQ entry until MemGnt.
- Reset asserted mid-transfer forces IDLE on the next edge and drops MemReq. A late MemDone after reset is ignored.
- A selected accept while the FSM is in REQ or WAIT cannot occur, because HREADY is low then. It needs no handling.

## Configuration

- EXTMEM_TIMEOUT_EN defined:
  - A counter clears on REQ entry and increments each cycle in REQ or WAIT.
  - When it reaches TIMEOUT_CYCLES, go to ERR1 and drop MemReq.
  - Any later MemDone for that request is ignored until the next REQ.
- EXTMEM_TIMEOUT_EN undefined: the counter logic is absent and the bridge waits indefinitely. TIMEOUT_CYCLES is unused.

## Structure

- Shared package holds:
  - the bridge state enum typedef;
  - HTRANS encodings (IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11);
  - HRESP encodings (OKAY=0, ERROR=1).
- Sub-module extmem_timeout holds the saturating counter and comparator. It is instantiated only under EXTMEM_TIMEOUT_EN.

## Test plan

- 64-bit read at 0x8000_0000, HSIZE=3; MemGnt at cycle 1, MemDone at cycle 4 with MemRData=0xDEADBEEF_01234567 -> HREADYEXT low for cycles 1–4, high at cycle 5 with that data and HRESPEXT=0.
- Write at 0x8000_0004, HSIZE=2, HWSTRB=0xF0, HWDATA=0x11223344_00000000 -> MemWrite=1, MemAdr=0x8000_0000, MemByteEn=0xF0, data passed through unchanged; OKAY after MemDone.
- Misaligned access (HSIZE=2, HADDR=0x8000_0002) -> no MemReq; cycle 1 HRESPEXT=1/HREADYEXT=0, cycle 2 HRESPEXT=1/HREADYEXT=1.
- Back-to-back reads, with the second address phase issued in the first read's DONE cycle -> second MemReq in the cycle after DONE, with no IDLE gap.
- MemDone with MemErr=1 -> two-cycle ERROR response. Reset asserted while in WAIT -> MemReq=0 and HREADYEXT=1 next cycle.
- With EXTMEM_TIMEOUT_EN defined and TIMEOUT_CYCLES=8, MemGnt given but MemDone never asserted -> ERR1 eight cycles after REQ entry. A MemDone arriving later causes no response.

Source files
------------

// File: rtl/ahb_ext_bridge_pkg.sv
// Shared types for the external-memory AHB bridge: FSM states, AHB encodings, alignment helper.
package ahb_ext_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE,
        ST_ERR1,
        ST_ERR2
    } bridge_state_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Sizes above a doubleword are rejected separately by the width check.
    function automatic logic addr_aligned(input logic [2:0] lsb, input logic [2:0] size);
        case (size)
            3'd0:    return 1'b1;
            3'd1:    return lsb[0] == 1'b0;
            3'd2:    return lsb[1:0] == 2'b00;
            3'd3:    return lsb == 3'b000;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_ext_bridge_if.sv
// Bundles the AHB-Lite subordinate port and the memory-side request/response port.
// slave = bridge view; master = SoC/memory-controller view.
interface ahb_ext_bridge_if #(
    parameter int AHBW    = 64,
    parameter int PA_BITS = 34
);
    logic                 HSELEXT;
    logic [PA_BITS-1:0]   HADDR;
    logic [1:0]           HTRANS;
    logic                 HWRITE;
    logic [2:0]           HSIZE;
    logic [AHBW-1:0]      HWDATA;
    logic [AHBW/8-1:0]    HWSTRB;
    logic                 HREADY;
    logic [AHBW-1:0]      HRDATAEXT;
    logic                 HREADYEXT;
    logic                 HRESPEXT;

    logic                 MemReq;
    logic                 MemWrite;
    logic [PA_BITS-1:0]   MemAdr;
    logic [AHBW-1:0]      MemWData;
    logic [AHBW/8-1:0]    MemByteEn;
    logic                 MemGnt;
    logic                 MemDone;
    logic [AHBW-1:0]      MemRData;
    logic                 MemErr;

    modport slave (
        input  HSELEXT, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HWSTRB, HREADY,
        output HRDATAEXT, HREADYEXT, HRESPEXT,
        output MemReq, MemWrite, MemAdr, MemWData, MemByteEn,
        input  MemGnt, MemDone, MemRData, MemErr
    );

    modport master (
        output HSELEXT, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HWSTRB, HREADY,
        input  HRDATAEXT, HREADYEXT, HRESPEXT,
        input  MemReq, MemWrite, MemAdr, MemWData, MemByteEn,
        output MemGnt, MemDone, MemRData, MemErr
    );

endinterface

// File: rtl/extmem_timeout.sv
// Saturating wait-state counter; expired pulses on the cycle whose edge brings the count to TIMEOUT_CYCLES.
module extmem_timeout #(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expired
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (run && (cnt_q != CNT_W'(TIMEOUT_CYCLES))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign expired = run && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ahb_ext_bridge.sv
// AHB-Lite HSELEXT subordinate turning each transfer into one memory request; two wait states minimum,
// HREADYEXT held low until MemDone. EXTMEM_TIMEOUT_EN adds an ERROR abort after TIMEOUT_CYCLES.
module ahb_ext_bridge
    import ahb_ext_bridge_pkg::*;
#(
    parameter int AHBW           = 64,
    parameter int PA_BITS        = 34,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic            clk,
    input  logic            reset,
    ahb_ext_bridge_if.slave bus
);
    localparam int BE_W  = AHBW / 8;
    localparam int ALIGN = $clog2(BE_W);

    bridge_state_e       state_q, state_d;
    logic                hready_q, hready_d;
    logic                hresp_q, hresp_d;
    logic [AHBW-1:0]     rdata_q, rdata_d;
    logic                req_q, req_d;
    logic                write_q, write_d;
    logic [PA_BITS-1:0]  adr_q, adr_d;
    logic [AHBW-1:0]     wdata_q, wdata_d;
    logic [BE_W-1:0]     be_q, be_d;

    logic accept, legal, start_req, req_wr, timed_out, busy;

    always_comb begin
        accept    = bus.HSELEXT && bus.HREADY &&
                    (bus.HTRANS == HTRANS_NONSEQ || bus.HTRANS == HTRANS_SEQ);
        legal     = (bus.HSIZE <= 3'(ALIGN)) && addr_aligned(bus.HADDR[2:0], bus.HSIZE);
        req_wr    = (state_q == ST_REQ) && write_q;
        busy      = (state_q == ST_REQ) || (state_q == ST_WAIT);
        start_req = 1'b0;
        state_d   = state_q;
        rdata_d   = rdata_q;
        write_d   = write_q;
        adr_d     = adr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR2: begin
                state_d = ST_IDLE;
                if (accept) begin
                    if (legal) begin
                        state_d   = ST_REQ;
                        start_req = 1'b1;
                        write_d   = bus.HWRITE;
                        adr_d     = {bus.HADDR[PA_BITS-1:ALIGN], {ALIGN{1'b0}}};
                        if (!bus.HWRITE) begin
                            be_d = '1;
                        end
                    end else begin
                        state_d = ST_ERR1;
                    end
                end
            end
            ST_REQ: begin
                // Write data arrives in the data phase, i.e. while we sit in REQ.
                if (req_wr) begin
                    wdata_d = bus.HWDATA;
                    be_d    = bus.HWSTRB;
                end
                if (timed_out) begin
                    state_d = ST_ERR1;
                end else if (bus.MemGnt) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (timed_out) begin
                    state_d = ST_ERR1;
                end else if (bus.MemDone) begin
                    if (bus.MemErr) begin
                        state_d = ST_ERR1;
                    end else begin
                        state_d = ST_DONE;
                        if (!write_q) begin
                            rdata_d = bus.MemRData;
                        end
                    end
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = ST_IDLE;
        endcase

        req_d    = (state_d == ST_REQ);
        hready_d = !(state_d inside {ST_REQ, ST_WAIT, ST_ERR1});
        hresp_d  = (state_d inside {ST_ERR1, ST_ERR2}) ? HRESP_ERROR : HRESP_OKAY;
    end

`ifdef EXTMEM_TIMEOUT_EN
    extmem_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (start_req),
        .run     (busy),
        .expired (timed_out)
    );
`else
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            hready_q <= 1'b1;
            hresp_q  <= HRESP_OKAY;
            rdata_q  <= '0;
            req_q    <= 1'b0;
            write_q  <= 1'b0;
            adr_q    <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
        end else begin
            state_q  <= state_d;
            hready_q <= hready_d;
            hresp_q  <= hresp_d;
            rdata_q  <= rdata_d;
            req_q    <= req_d;
            write_q  <= write_d;
            adr_q    <= adr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
        end
    end

    assign bus.HRDATAEXT = rdata_q;
    assign bus.HREADYEXT = hready_q;
    assign bus.HRESPEXT  = hresp_q;
    assign bus.MemReq    = req_q;
    assign bus.MemWrite  = write_q;
    assign bus.MemAdr    = adr_q;
    assign bus.MemWData  = req_wr ? bus.HWDATA : wdata_q;
    assign bus.MemByteEn = req_wr ? bus.HWSTRB : be_q;

endmodule

// File: tb/tb_ahb_ext_bridge.sv
// Directed bench for ahb_ext_bridge: reads, writes, illegal transfers, back-to-back, MemErr, reset, timeout.
module tb_ahb_ext_bridge;
    import ahb_ext_bridge_pkg::*;

    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    ahb_ext_bridge_if #(.AHBW(64), .PA_BITS(34)) bus ();

    // The bridge is the only subordinate here, so the global HREADY is its own.
    assign bus.HREADY = bus.HREADYEXT;

    ahb_ext_bridge #(
        .AHBW           (64),
        .PA_BITS        (34),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        bus.HSELEXT = 1'b0;
        bus.HTRANS  = HTRANS_IDLE;
        bus.HWRITE  = 1'b0;
        bus.HSIZE   = 3'd0;
        bus.HADDR   = '0;
    endtask

    task automatic addr_ph(input logic wr, input logic [2:0] size, input logic [33:0] addr);
        bus.HSELEXT = 1'b1;
        bus.HTRANS  = HTRANS_NONSEQ;
        bus.HWRITE  = wr;
        bus.HSIZE   = size;
        bus.HADDR   = addr;
    endtask

    initial begin
        reset        = 1'b1;
        bus_idle();
        bus.HWDATA   = '0;
        bus.HWSTRB   = '0;
        bus.MemGnt   = 1'b0;
        bus.MemDone  = 1'b0;
        bus.MemErr   = 1'b0;
        bus.MemRData = '0;

        tick(); tick(); #2;
        check_eq("rst_hready", bus.HREADYEXT, 1);
        check_eq("rst_hresp",  bus.HRESPEXT, 0);
        check_eq("rst_hrdata", bus.HRDATAEXT, 0);
        check_eq("rst_memreq", bus.MemReq, 0);
        check_eq("rst_memwr",  bus.MemWrite, 0);
        check_eq("rst_memadr", bus.MemAdr, 0);
        check_eq("rst_wdata",  bus.MemWData, 0);
        check_eq("rst_be",     bus.MemByteEn, 0);
        tick(); reset = 1'b0;

        // 64-bit read, MemGnt cycle 1, MemDone cycle 4
        tick(); addr_ph(1'b0, 3'd3, 34'h0_8000_0000); #2;
        check_eq("rd_c0_hready", bus.HREADYEXT, 1);
        tick(); bus_idle(); bus.MemGnt = 1'b1; #2;
        check_eq("rd_c1_memreq", bus.MemReq, 1);
        check_eq("rd_c1_adr",    bus.MemAdr, 64'h8000_0000);
        check_eq("rd_c1_wr",     bus.MemWrite, 0);
        check_eq("rd_c1_be",     bus.MemByteEn, 64'hFF);
        check_eq("rd_c1_hready", bus.HREADYEXT, 0);
        tick(); bus.MemGnt = 1'b0; #2;
        check_eq("rd_c2_hready", bus.HREADYEXT, 0);
        check_eq("rd_c2_memreq", bus.MemReq, 0);
        tick(); #2;
        check_eq("rd_c3_hready", bus.HREADYEXT, 0);
        tick(); bus.MemDone = 1'b1; bus.MemRData = 64'hDEADBEEF_01234567; #2;
        check_eq("rd_c4_hready", bus.HREADYEXT, 0);
        tick(); bus.MemDone = 1'b0; bus.MemRData = '0; #2;
        check_eq("rd_c5_hready", bus.HREADYEXT, 1);
        check_eq("rd_c5_hresp",  bus.HRESPEXT, 0);
        check_eq("rd_c5_data",   bus.HRDATAEXT, 64'hDEADBEEF_01234567);
        tick(); #2;
        check_eq("rd_hold_data", bus.HRDATAEXT, 64'hDEADBEEF_01234567);

        // word write to upper half, MemGnt delayed one cycle
        tick(); addr_ph(1'b1, 3'd2, 34'h0_8000_0004); #2;
        tick(); bus_idle(); bus.HWDATA = 64'h11223344_00000000; bus.HWSTRB = 8'hF0; #2;
        check_eq("wr_c1_memreq", bus.MemReq, 1);
        check_eq("wr_c1_wr",     bus.MemWrite, 1);
        check_eq("wr_c1_adr",    bus.MemAdr, 64'h8000_0000);
        check_eq("wr_c1_wdata",  bus.MemWData, 64'h11223344_00000000);
        check_eq("wr_c1_be",     bus.MemByteEn, 64'hF0);
        check_eq("wr_c1_hready", bus.HREADYEXT, 0);
        tick(); bus.MemGnt = 1'b1; #2;
        check_eq("wr_c2_memreq", bus.MemReq, 1);
        check_eq("wr_c2_wdata",  bus.MemWData, 64'h11223344_00000000);
        check_eq("wr_c2_be",     bus.MemByteEn, 64'hF0);
        tick(); bus.MemGnt = 1'b0; bus.MemDone = 1'b1; #2;
        check_eq("wr_c3_memreq", bus.MemReq, 0);
        check_eq("wr_c3_hready", bus.HREADYEXT, 0);
        tick(); bus.MemDone = 1'b0; #2;
        check_eq("wr_c4_hready", bus.HREADYEXT, 1);
        check_eq("wr_c4_hresp",  bus.HRESPEXT, 0);
        check_eq("wr_keep_data", bus.HRDATAEXT, 64'hDEADBEEF_01234567);

        // misaligned word access
        tick(); bus.HWDATA = '0; bus.HWSTRB = '0; addr_ph(1'b0, 3'd2, 34'h0_8000_0002); #2;
        tick(); bus_idle(); #2;
        check_eq("mis_c1_memreq", bus.MemReq, 0);
        check_eq("mis_c1_hresp",  bus.HRESPEXT, 1);
        check_eq("mis_c1_hready", bus.HREADYEXT, 0);
        tick(); #2;
        check_eq("mis_c2_hresp",  bus.HRESPEXT, 1);
        check_eq("mis_c2_hready", bus.HREADYEXT, 1);
        check_eq("mis_c2_memreq", bus.MemReq, 0);
        tick(); #2;
        check_eq("mis_c3_hresp",  bus.HRESPEXT, 0);
        check_eq("mis_c3_hready", bus.HREADYEXT, 1);

        // oversize transfer (16 bytes on a 64-bit bus)
        tick(); addr_ph(1'b0, 3'd4, 34'h0_8000_0000); #2;
        tick(); bus_idle(); #2;
        check_eq("big_hresp",  bus.HRESPEXT, 1);
        check_eq("big_memreq", bus.MemReq, 0);
        tick(); tick();

        // back-to-back reads, second address phase in the first DONE cycle
        tick(); addr_ph(1'b0, 3'd3, 34'h0_8000_0010); #2;
        tick(); bus_idle(); bus.MemGnt = 1'b1; #2;
        tick(); bus.MemGnt = 1'b0; bus.MemDone = 1'b1; bus.MemRData = 64'hA5A5A5A5_00000001; #2;
        tick(); bus.MemDone = 1'b0; addr_ph(1'b0, 3'd3, 34'h0_8000_0020); #2;
        check_eq("b2b_done_hready", bus.HREADYEXT, 1);
        check_eq("b2b_done_data",   bus.HRDATAEXT, 64'hA5A5A5A5_00000001);
        tick(); bus_idle(); bus.MemGnt = 1'b1; #2;
        check_eq("b2b_req2",        bus.MemReq, 1);
        check_eq("b2b_adr2",        bus.MemAdr, 64'h8000_0020);
        check_eq("b2b_req2_hready", bus.HREADYEXT, 0);
        tick(); bus.MemGnt = 1'b0; bus.MemDone = 1'b1; bus.MemRData = 64'h5A5A5A5A_00000002; #2;
        tick(); bus.MemDone = 1'b0; #2;
        check_eq("b2b_done2_hready", bus.HREADYEXT, 1);
        check_eq("b2b_done2_data",   bus.HRDATAEXT, 64'h5A5A5A5A_00000002);

        // completion error
        tick(); addr_ph(1'b0, 3'd3, 34'h0_8000_0040); #2;
        tick(); bus_idle(); bus.MemGnt = 1'b1; #2;
        tick(); bus.MemGnt = 1'b0; bus.MemDone = 1'b1; bus.MemErr = 1'b1; bus.MemRData = 64'h55555555_55555555; #2;
        tick(); bus.MemDone = 1'b0; bus.MemErr = 1'b0; #2;
        check_eq("err_c3_hresp",  bus.HRESPEXT, 1);
        check_eq("err_c3_hready", bus.HREADYEXT, 0);
        tick(); #2;
        check_eq("err_c4_hresp",  bus.HRESPEXT, 1);
        check_eq("err_c4_hready", bus.HREADYEXT, 1);
        check_eq("err_keep_data", bus.HRDATAEXT, 64'h5A5A5A5A_00000002);
        tick(); #2;
        check_eq("err_c5_hresp",  bus.HRESPEXT, 0);

        // reset while in REQ drops MemReq
        tick(); addr_ph(1'b0, 3'd3, 34'h0_8000_0060); #2;
        tick(); bus_idle(); reset = 1'b1; #2;
        check_eq("rstreq_memreq_before", bus.MemReq, 1);
        tick(); reset = 1'b0; #2;
        check_eq("rstreq_memreq_after", bus.MemReq, 0);
        check_eq("rstreq_hready",       bus.HREADYEXT, 1);

        // reset while in WAIT, late MemDone afterwards
        tick(); addr_ph(1'b0, 3'd3, 34'h0_8000_0080); #2;
        tick(); bus_idle(); bus.MemGnt = 1'b1; #2;
        tick(); bus.MemGnt = 1'b0; reset = 1'b1; #2;
        check_eq("rstw_wait_hready", bus.HREADYEXT, 0);
        tick(); reset = 1'b0; bus.MemDone = 1'b1; bus.MemRData = 64'h77777777_77777777; #2;
        check_eq("rstw_memreq", bus.MemReq, 0);
        check_eq("rstw_hready", bus.HREADYEXT, 1);
        check_eq("rstw_hrdata", bus.HRDATAEXT, 0);
        tick(); bus.MemDone = 1'b0; #2;
        check_eq("rstw_late_hready", bus.HREADYEXT, 1);
        check_eq("rstw_late_hrdata", bus.HRDATAEXT, 0);

        // BUSY transfer gets a zero-wait OKAY
        tick(); bus.HSELEXT = 1'b1; bus.HTRANS = HTRANS_BUSY; bus.HADDR = 34'h0_8000_0000; #2;
        tick(); bus_idle(); #2;
        check_eq("busy_hready", bus.HREADYEXT, 1);
        check_eq("busy_hresp",  bus.HRESPEXT, 0);
        check_eq("busy_memreq", bus.MemReq, 0);

        // stalled completion: ERROR after 8 cycles when enabled, otherwise wait indefinitely
        tick(); addr_ph(1'b0, 3'd3, 34'h0_8000_0100); #2;
        tick(); bus_idle(); bus.MemGnt = 1'b1; #2;
`ifdef EXTMEM_TIMEOUT_EN
        for (int c = 2; c <= 8; c++) begin
            tick(); bus.MemGnt = 1'b0; #2;
            check_eq($sformatf("to_c%0d_hready", c), bus.HREADYEXT, 0);
        end
        tick(); #2;
        check_eq("to_c9_hresp",  bus.HRESPEXT, 1);
        check_eq("to_c9_hready", bus.HREADYEXT, 0);
        check_eq("to_c9_memreq", bus.MemReq, 0);
        tick(); #2;
        check_eq("to_c10_hresp",  bus.HRESPEXT, 1);
        check_eq("to_c10_hready", bus.HREADYEXT, 1);
        tick(); bus.MemDone = 1'b1; bus.MemRData = 64'h99999999_99999999; #2;
        tick(); bus.MemDone = 1'b0; #2;
        check_eq("to_late_hready", bus.HREADYEXT, 1);
        check_eq("to_late_hresp",  bus.HRESPEXT, 0);
        check_eq("to_late_hrdata", bus.HRDATAEXT, 0);
`else
        for (int c = 2; c <= 20; c++) begin
            tick(); bus.MemGnt = 1'b0; #2;
            if (c == 20) begin
                check_eq("nto_hready", bus.HREADYEXT, 0);
                check_eq("nto_hresp",  bus.HRESPEXT, 0);
            end
        end
        tick(); bus.MemDone = 1'b1; bus.MemRData = 64'hC0FFEE00_12345678; #2;
        tick(); bus.MemDone = 1'b0; #2;
        check_eq("nto_done_hready", bus.HREADYEXT, 1);
        check_eq("nto_done_data",   bus.HRDATAEXT, 64'hC0FFEE00_12345678);
`endif

        tick(); tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
